// File: rtl/turn_controller_if.sv
// Turn controller bus: start/phase request, player buttons and digit value in,
// assembled code with valid/ready handshake and status pulses out.
// The master modport drives requests and buttons; the slave modport is the controller.
interface turn_controller_if;
  logic        start;
  logic        phase;
  logic        maker_is_A;
  logic        enterA;
  logic        enterB;
  logic [2:0]  SW;
  logic        code_ready;
  logic [11:0] code_out;
  logic        code_valid;
  logic        active_p;
  logic [1:0]  digit_idx;
  logic        busy;
  logic        reject;
  logic        illegal_press;
  logic        timeout;

  modport master (
    output start, phase, maker_is_A, enterA, enterB, SW, code_ready,
    input  code_out, code_valid, active_p, digit_idx, busy, reject, illegal_press, timeout
  );

  modport slave (
    input  start, phase, maker_is_A, enterA, enterB, SW, code_ready,
    output code_out, code_valid, active_p, digit_idx, busy, reject, illegal_press, timeout
  );
endinterface

// File: rtl/turn_controller.sv
// Collects a 4-digit code (digits 0..5) from the active player, then offers it downstream.
// Latency: a press edge is reflected in code_out/digit_idx/pulses one cycle later.
// Backpressure: code_valid and code_out hold in OFFER until code_ready; no timeout there.
module turn_controller #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  turn_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, OFFER} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic [11:0] code_q, code_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic        enter_a_q, enter_b_q;
  logic        reject_q, reject_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;

  logic        press_a, press_b, act_press, oth_press;

  // Rising edges against the registered button copies; held buttons give one press.
  assign press_a   = bus.enterA & ~enter_a_q;
  assign press_b   = bus.enterB & ~enter_b_q;
  assign act_press = active_q ? press_b : press_a;
  assign oth_press = active_q ? press_a : press_b;

  // Next-state, datapath and pulse decisions for the turn FSM.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    code_d    = code_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    reject_d  = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Maker entry selects the maker, guess entry selects the breaker.
          active_d = bus.phase ? bus.maker_is_A : ~bus.maker_is_A;
          code_d   = 12'd0;
          idx_d    = 2'd0;
          timer_d  = 16'd0;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (oth_press) illegal_d = 1'b1;
        if (act_press) begin
          // Any active press, accepted or rejected, restarts the inactivity timer.
          timer_d = 16'd0;
          if (bus.SW <= 3'd5) begin
            case (idx_q)
              2'd0:    code_d[11:9] = bus.SW;
              2'd1:    code_d[8:6]  = bus.SW;
              2'd2:    code_d[5:3]  = bus.SW;
              default: code_d[2:0]  = bus.SW;
            endcase
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = OFFER;
          end else begin
            reject_d = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          code_d    = 12'd0;
          idx_d     = 2'd0;
          timer_d   = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      OFFER: begin
        if (bus.code_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath, edge-detector and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      code_q    <= 12'd0;
      idx_q     <= 2'd0;
      timer_q   <= 16'd0;
      enter_a_q <= 1'b0;
      enter_b_q <= 1'b0;
      reject_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      enter_a_q <= bus.enterA;
      enter_b_q <= bus.enterB;
      reject_q  <= reject_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.code_out      = code_q;
  assign bus.code_valid    = (state_q == OFFER);
  assign bus.active_p      = active_q;
  assign bus.digit_idx     = idx_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.reject        = reject_q;
  assign bus.illegal_press = illegal_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed turns with hand-computed codes; expected
// transfers and pulses go into a queue that a negedge monitor pops and compares.
module tb_turn_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  turn_controller_if tif();

  turn_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  typedef enum int {EV_CODE, EV_REJECT, EV_ILLEGAL, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [11:0] val;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [11:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input ev_kind_t k, input logic [11:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected actual=%s val=0x%0h required=none", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val !== v) begin
        failures++;
        $display("FAIL event_order actual=%s val=0x%0h required=%s val=0x%0h",
                 k.name(), v, e.kind.name(), e.val);
      end
    end
  endtask

  // Monitor: every transfer or status pulse the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (tif.code_valid && tif.code_ready) pop_cmp(EV_CODE, tif.code_out);
      if (tif.reject)        pop_cmp(EV_REJECT, 12'd0);
      if (tif.illegal_press) pop_cmp(EV_ILLEGAL, 12'd0);
      if (tif.timeout)       pop_cmp(EV_TIMEOUT, 12'd0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit b, input logic [2:0] sw);
    tif.SW = sw;
    if (b) tif.enterB = 1'b1;
    else   tif.enterA = 1'b1;
    tick();
    tif.enterA = 1'b0;
    tif.enterB = 1'b0;
    tick();
  endtask

  task automatic do_start(input bit ph, input bit maker_a);
    tif.phase      = ph;
    tif.maker_is_A = maker_a;
    tif.start      = 1'b1;
    tick();
    tif.start = 1'b0;
  endtask

  task automatic accept(input string name, input logic [11:0] code);
    check({name, "_valid"}, 32'(tif.code_valid), 32'd1);
    check({name, "_code"}, 32'(tif.code_out), 32'(code));
    push_ev(EV_CODE, code);
    tick();
    tick();
    check({name, "_held_valid"}, 32'(tif.code_valid), 32'd1);
    check({name, "_held_code"}, 32'(tif.code_out), 32'(code));
    tif.code_ready = 1'b1;
    tick();
    tif.code_ready = 1'b0;
    check({name, "_valid_after"}, 32'(tif.code_valid), 32'd0);
    check({name, "_busy_after"}, 32'(tif.busy), 32'd0);
    check({name, "_code_kept"}, 32'(tif.code_out), 32'(code));
  endtask

  initial begin
    tif.start = 1'b0; tif.phase = 1'b0; tif.maker_is_A = 1'b0;
    tif.enterA = 1'b0; tif.enterB = 1'b0; tif.SW = 3'd0; tif.code_ready = 1'b0;
    repeat (3) tick();
    check("rst_code", 32'(tif.code_out), 32'd0);
    check("rst_valid", 32'(tif.code_valid), 32'd0);
    check("rst_busy", 32'(tif.busy), 32'd0);
    check("rst_idx", 32'(tif.digit_idx), 32'd0);
    check("rst_active", 32'(tif.active_p), 32'd0);
    check("rst_pulses", 32'({tif.reject, tif.illegal_press, tif.timeout}), 32'd0);
    reset = 1'b0;
    tick();

    // Maker A enters 1,2,3,4 -> 0x29C.
    do_start(1'b0, 1'b1);
    check("t1_active", 32'(tif.active_p), 32'd0);
    check("t1_busy", 32'(tif.busy), 32'd1);
    press(1'b0, 3'd1); check("t1_idx1", 32'(tif.digit_idx), 32'd1);
    press(1'b0, 3'd2); check("t1_idx2", 32'(tif.digit_idx), 32'd2);
    press(1'b0, 3'd3); check("t1_idx3", 32'(tif.digit_idx), 32'd3);
    press(1'b0, 3'd4); check("t1_idx_wrap", 32'(tif.digit_idx), 32'd0);
    press(1'b0, 3'd5);
    check("t1_offer_press_code", 32'(tif.code_out), 32'h29C);
    accept("t1", 12'h29C);
    press(1'b1, 3'd3);
    check("t1_idle_press_busy", 32'(tif.busy), 32'd0);
    check("t1_idle_press_code", 32'(tif.code_out), 32'h29C);

    // Guess entry with maker A: B is active, A presses are illegal -> 0xA28.
    do_start(1'b1, 1'b1);
    check("t2_active", 32'(tif.active_p), 32'd1);
    push_ev(EV_ILLEGAL, 12'd0);
    press(1'b0, 3'd2); check("t2_illegal_idx_a", 32'(tif.digit_idx), 32'd0);
    push_ev(EV_ILLEGAL, 12'd0);
    press(1'b0, 3'd3); check("t2_illegal_idx_b", 32'(tif.digit_idx), 32'd0);
    press(1'b1, 3'd5); check("t2_idx1", 32'(tif.digit_idx), 32'd1);
    do_start(1'b0, 1'b0);
    check("t2_start_ignored_active", 32'(tif.active_p), 32'd1);
    check("t2_start_ignored_idx", 32'(tif.digit_idx), 32'd1);
    press(1'b1, 3'd0);
    press(1'b1, 3'd5);
    press(1'b1, 3'd0);
    accept("t2", 12'hA28);

    // Reject SW=7, then 2 in slot 0; both buttons with SW=3 -> 0x4C0.
    do_start(1'b0, 1'b0);
    check("t3_active", 32'(tif.active_p), 32'd1);
    push_ev(EV_REJECT, 12'd0);
    press(1'b1, 3'd7); check("t3_reject_idx", 32'(tif.digit_idx), 32'd0);
    press(1'b1, 3'd2); check("t3_slot0_code", 32'(tif.code_out), 32'h400);
    push_ev(EV_ILLEGAL, 12'd0);
    tif.SW = 3'd3; tif.enterA = 1'b1; tif.enterB = 1'b1;
    tick();
    tif.enterA = 1'b0; tif.enterB = 1'b0;
    tick();
    check("t3_both_idx", 32'(tif.digit_idx), 32'd2);
    check("t3_both_code", 32'(tif.code_out), 32'h4C0);
    press(1'b1, 3'd0);
    press(1'b1, 3'd0);
    accept("t3", 12'h4C0);

    // Two digits then silence: timeout 8 cycles after the last accepted press.
    do_start(1'b0, 1'b1);
    press(1'b0, 3'd3);
    press(1'b0, 3'd5);
    repeat (6) tick();
    check("t4_pre_timeout", 32'(tif.timeout), 32'd0);
    check("t4_pre_busy", 32'(tif.busy), 32'd1);
    push_ev(EV_TIMEOUT, 12'd0);
    tick();
    check("t4_timeout", 32'(tif.timeout), 32'd1);
    check("t4_busy", 32'(tif.busy), 32'd0);
    check("t4_code", 32'(tif.code_out), 32'd0);
    check("t4_idx", 32'(tif.digit_idx), 32'd0);

    // Press on the terminal timer cycle wins over the timeout.
    do_start(1'b0, 1'b1);
    repeat (7) tick();
    press(1'b0, 3'd1);
    check("t5_prec_busy", 32'(tif.busy), 32'd1);
    check("t5_prec_idx", 32'(tif.digit_idx), 32'd1);
    press(1'b0, 3'd2);
    press(1'b0, 3'd3);
    check("t5_idx3", 32'(tif.digit_idx), 32'd3);

    // Reset mid-turn with both buttons held.
    tif.enterA = 1'b1; tif.enterB = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(tif.busy), 32'd0);
    check("t6_rst_idx", 32'(tif.digit_idx), 32'd0);
    check("t6_rst_code", 32'(tif.code_out), 32'd0);
    check("t6_rst_valid", 32'(tif.code_valid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    do_start(1'b0, 1'b1);
    tick();
    tick();
    check("t6_held_idx", 32'(tif.digit_idx), 32'd0);
    check("t6_held_busy", 32'(tif.busy), 32'd1);
    tif.enterA = 1'b0; tif.enterB = 1'b0;
    tick();
    press(1'b0, 3'd4);
    check("t6_clean_idx", 32'(tif.digit_idx), 32'd1);
    check("t6_clean_code", 32'(tif.code_out), 32'h800);

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
